// File: rtl/avl_arb_pkg.sv
// ----------------------------------------------------------------------------
// avl_arb_pkg
//   Shared types and constants for the two-master Avalon-MM bus arbiter.
//   arb_state_t : arbiter state (IDLE, BUSY_I, BUSY_D)
//   GNT_I/GNT_D : one-hot grant encodings, {D,I}
// ----------------------------------------------------------------------------
package avl_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/avl_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// avl_bus_arbiter_if
//   Non-pipelined Avalon-MM bus bundle.
//   Parameters : ADDR_W, DATA_W (byteenable width is DATA_W/8)
//   Signals    : address, read, write, writedata, byteenable  (master -> slave)
//                readdata, waitrequest                       (slave -> master)
//   Modports   : master - the side issuing transfers
//                slave  - the side answering transfers
// ----------------------------------------------------------------------------
interface avl_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avl_arb_wdog.sv
// ----------------------------------------------------------------------------
// avl_arb_wdog
//   Stall watchdog. Counts consecutive busy cycles in which the slave holds
//   waitrequest; the count clears whenever the bus is idle or the slave
//   accepts. When a stall cycle is seen with the count already at
//   TIMEOUT_CYCLES-1 the sticky error flag sets and holds until reset.
//   Only observes the bus; it never aborts a transfer.
//   Parameters : TIMEOUT_CYCLES (>= 2)
//   Ports      : clk, reset (async, active-high)
//                busy        - arbiter owns the slave for some master
//                waitrequest - slave stall
//                timeout_err - sticky watchdog flag
// ----------------------------------------------------------------------------
module avl_arb_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic waitrequest,
    output logic timeout_err
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             stall;

    assign stall = busy & waitrequest;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!stall)
                count <= '0;
            else if (count != CNT_MAX)
                count <= count + 1'b1;    // saturates; flag is sticky anyway

            if (stall && count == CNT_MAX)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: rtl/avl_bus_arbiter.sv
// ----------------------------------------------------------------------------
// avl_bus_arbiter
//   Shares one Avalon-MM memory slave between the CPU instruction-fetch port
//   (I, read only) and the load/store port (D). One outstanding transfer at a
//   time; the grant is held by the state register until the slave completes.
//   D wins from IDLE; on completion the other master is served next if it is
//   requesting, so contention alternates with no bubble and no starvation.
//
//   Parameters : ADDR_W, DATA_W, TIMEOUT_CYCLES (watchdog only)
//   Ports      : clk, reset     - clock, async active-high reset
//                i_port (slave) - I master bus; write/writedata/byteenable ignored
//                d_port (slave) - D master bus
//                m_port (master)- bus to the memory slave
//                grant          - {D,I} one-hot owner, 2'b00 when idle
//                timeout_err    - sticky stall watchdog flag
//   Optional   : define ARB_TIMEOUT_EN to build the stall watchdog
//                (avl_arb_wdog); otherwise timeout_err is tied to 0.
// ----------------------------------------------------------------------------
module avl_bus_arbiter
    import avl_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    avl_bus_arbiter_if.slave       i_port,
    avl_bus_arbiter_if.slave       d_port,
    avl_bus_arbiter_if.master      m_port,
    output logic [1:0]             grant,
    output logic                   timeout_err
);
    localparam int BE_W = DATA_W / 8;

    arb_state_t state;
    logic       i_req;
    logic       d_req;

    assign i_req = i_port.read;
    assign d_req = d_port.read | d_port.write;

    // Read data is broadcast; each master only trusts it when its own
    // waitrequest is low, which happens only while it owns the slave.
    assign i_port.readdata = m_port.readdata;
    assign d_port.readdata = m_port.readdata;

    // ------------------------------------------------------------------
    // Arbitration state. The owner's own next request is deliberately not
    // looked at in its completion cycle so the other master gets a turn.
    // ------------------------------------------------------------------
    // NOTE: state is sequential, so it is assigned with <= only; a blocking
    // assignment here would let same-edge readers see the new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (d_req)
                        state <= BUSY_D;
                    else if (i_req)
                        state <= BUSY_I;
                end
                BUSY_I: begin
                    if (i_req && !m_port.waitrequest)
                        state <= d_req ? BUSY_D : IDLE;
                end
                BUSY_D: begin
                    if (d_req && !m_port.waitrequest)
                        state <= i_req ? BUSY_I : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus steering, decoded from the state register only, so reset takes
    // the slave-side strobes low in the same cycle it is asserted.
    // ------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        m_port.address    = {ADDR_W{1'b0}};
        m_port.read       = 1'b0;
        m_port.write      = 1'b0;
        m_port.writedata  = {DATA_W{1'b0}};
        m_port.byteenable = {BE_W{1'b0}};
        i_port.waitrequest = 1'b1;
        d_port.waitrequest = 1'b1;
        grant             = GNT_NONE;

        unique case (state)
            BUSY_I: begin
                m_port.address     = i_port.address;
                m_port.read        = i_port.read;
                m_port.byteenable  = {BE_W{1'b1}};   // fetches are full words
                i_port.waitrequest = m_port.waitrequest;
                grant              = GNT_I;
            end
            BUSY_D: begin
                m_port.address     = d_port.address;
                m_port.read        = d_port.read;
                m_port.write       = d_port.write;
                m_port.writedata   = d_port.writedata;
                m_port.byteenable  = d_port.byteenable;
                d_port.waitrequest = m_port.waitrequest;
                grant              = GNT_D;
            end
            default: ;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    logic busy;

    assign busy = (state != IDLE);

    avl_arb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk         (clk),
        .reset       (reset),
        .busy        (busy),
        .waitrequest (m_port.waitrequest),
        .timeout_err (timeout_err)
    );
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_avl_bus_arbiter
//   Directed bench for avl_bus_arbiter. A small memory slave model answers
//   on m_bus with a programmable number of waitrequest cycles per transfer;
//   its 16 words are selected by address[15:12] and preloaded on reset.
//   Inputs are driven 1 time unit after the rising edge, outputs sampled
//   2 units after it.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_avl_bus_arbiter;
    import avl_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

`ifdef ARB_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] grant;
    logic       timeout_err;

    avl_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i_bus ();
    avl_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) d_bus ();
    avl_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();

    avl_bus_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_port      (i_bus),
        .d_port      (d_bus),
        .m_port      (m_bus),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory slave model ----------------
    logic [31:0] mem [16];
    int          wait_target;
    int          wait_cnt;
    logic [3:0]  idx;

    assign idx               = m_bus.address[15:12];
    assign m_bus.waitrequest = (m_bus.read | m_bus.write) && (wait_cnt < wait_target);
    assign m_bus.readdata    = mem[idx];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 0;
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
            mem[0] <= 32'h1234_5678;   // 0xBFC00000
            mem[2] <= 32'h2222_2222;   // 0x2000
            mem[3] <= 32'h3333_3333;   // 0x3000
            mem[4] <= 32'hCAFE_F00D;   // 0x4000
        end else if (m_bus.read | m_bus.write) begin
            if (m_bus.waitrequest) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt <= 0;
                if (m_bus.write) mem[idx] <= m_bus.writedata;
            end
        end
    end

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_grant"},  32'(grant), 32'(GNT_NONE));
        check({tag, "_mread"},  32'(m_bus.read), 32'd0);
        check({tag, "_mwrite"}, 32'(m_bus.write), 32'd0);
        check({tag, "_iwait"},  32'(i_bus.waitrequest), 32'd1);
        check({tag, "_dwait"},  32'(d_bus.waitrequest), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        wait_target = 0;
        i_bus.address = '0; i_bus.read = 1'b0; i_bus.write = 1'b0;
        i_bus.writedata = '0; i_bus.byteenable = '0;
        d_bus.address = '0; d_bus.read = 1'b0; d_bus.write = 1'b0;
        d_bus.writedata = '0; d_bus.byteenable = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #2;
        idle_checks("rst");
        check("rst_maddr", m_bus.address, 32'h0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        settle();

        // ---- 1: I only, zero wait ----
        i_bus.address = 32'hBFC0_0000;
        i_bus.read    = 1'b1;
        settle();
        check("t1_idle_grant", 32'(grant), 32'(GNT_NONE));
        check("t1_idle_mread", 32'(m_bus.read), 32'd0);
        check("t1_idle_iwait", 32'(i_bus.waitrequest), 32'd1);
        tick(); settle();
        check("t1_grant", 32'(grant), 32'(GNT_I));
        check("t1_mread", 32'(m_bus.read), 32'd1);
        check("t1_mwrite", 32'(m_bus.write), 32'd0);
        check("t1_maddr", m_bus.address, 32'hBFC0_0000);
        check("t1_mbe", 32'(m_bus.byteenable), 32'hF);
        check("t1_iwait", 32'(i_bus.waitrequest), 32'd0);
        check("t1_irdata", i_bus.readdata, 32'h1234_5678);
        check("t1_dwait", 32'(d_bus.waitrequest), 32'd1);
        tick();
        i_bus.read = 1'b0;
        settle();
        idle_checks("t1_end");

        // ---- 2: simultaneous I read and D write ----
        i_bus.address    = 32'h0000_1000;
        i_bus.read       = 1'b1;
        d_bus.address    = 32'h0000_1000;
        d_bus.write      = 1'b1;
        d_bus.writedata  = 32'hDEAD_BEEF;
        d_bus.byteenable = 4'hF;
        settle();
        tick(); settle();
        check("t2_d_grant", 32'(grant), 32'(GNT_D));
        check("t2_d_mwrite", 32'(m_bus.write), 32'd1);
        check("t2_d_mread", 32'(m_bus.read), 32'd0);
        check("t2_d_maddr", m_bus.address, 32'h0000_1000);
        check("t2_d_mwdata", m_bus.writedata, 32'hDEAD_BEEF);
        check("t2_d_mbe", 32'(m_bus.byteenable), 32'hF);
        check("t2_d_dwait", 32'(d_bus.waitrequest), 32'd0);
        check("t2_d_iwait", 32'(i_bus.waitrequest), 32'd1);
        tick();
        d_bus.write = 1'b0;
        settle();
        check("t2_i_grant", 32'(grant), 32'(GNT_I));
        check("t2_i_mread", 32'(m_bus.read), 32'd1);
        check("t2_i_iwait", 32'(i_bus.waitrequest), 32'd0);
        check("t2_i_rdata", i_bus.readdata, 32'hDEAD_BEEF);
        tick();
        i_bus.read = 1'b0;
        settle();
        check("t2_end_grant", 32'(grant), 32'(GNT_NONE));

        // ---- 3: continuous contention, 10 transfers ----
        i_bus.address = 32'h0000_3000;
        d_bus.address = 32'h0000_2000;
        i_bus.read    = 1'b1;
        d_bus.read    = 1'b1;
        settle();
        tick(); settle();
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                check($sformatf("t3_grant%0d", k), 32'(grant), 32'(GNT_D));
                check($sformatf("t3_maddr%0d", k), m_bus.address, 32'h0000_2000);
                check($sformatf("t3_dwait%0d", k), 32'(d_bus.waitrequest), 32'd0);
                check($sformatf("t3_drdata%0d", k), d_bus.readdata, 32'h2222_2222);
            end else begin
                check($sformatf("t3_grant%0d", k), 32'(grant), 32'(GNT_I));
                check($sformatf("t3_maddr%0d", k), m_bus.address, 32'h0000_3000);
                check($sformatf("t3_iwait%0d", k), 32'(i_bus.waitrequest), 32'd0);
                check($sformatf("t3_irdata%0d", k), i_bus.readdata, 32'h3333_3333);
            end
            if (k == 9) begin
                d_bus.read = 1'b0;   // D not owner here; stop it queuing
                settle();
            end
            tick(); settle();
        end
        i_bus.read = 1'b0;
        settle();
        idle_checks("t3_end");

        // ---- 4: D read with 3 wait cycles ----
        wait_target   = 3;
        d_bus.address = 32'h0000_4000;
        d_bus.read    = 1'b1;
        settle();
        tick(); settle();
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("t4_grant_c%0d", c), 32'(grant), 32'(GNT_D));
            check($sformatf("t4_maddr_c%0d", c), m_bus.address, 32'h0000_4000);
            check($sformatf("t4_dwait_c%0d", c), 32'(d_bus.waitrequest), 32'd1);
            tick(); settle();
        end
        check("t4_grant_c4", 32'(grant), 32'(GNT_D));
        check("t4_dwait_c4", 32'(d_bus.waitrequest), 32'd0);
        check("t4_drdata", d_bus.readdata, 32'hCAFE_F00D);
        tick();
        d_bus.read = 1'b0;
        settle();
        idle_checks("t4_end");

        // ---- 5: reset during stalled D write ----
        wait_target     = 100;
        d_bus.address   = 32'h0000_5000;
        d_bus.writedata = 32'h5555_AAAA;
        d_bus.write     = 1'b1;
        settle();
        tick(); settle();
        check("t5_busy_grant", 32'(grant), 32'(GNT_D));
        check("t5_busy_mwrite", 32'(m_bus.write), 32'd1);
        check("t5_busy_dwait", 32'(d_bus.waitrequest), 32'd1);
        reset = 1'b1;
        settle();
        idle_checks("t5_rst");
        d_bus.write = 1'b0;
        tick();
        reset = 1'b0;
        wait_target   = 0;
        i_bus.address = 32'hBFC0_0000;
        i_bus.read    = 1'b1;
        settle();
        tick(); settle();
        check("t5_after_grant", 32'(grant), 32'(GNT_I));
        check("t5_after_iwait", 32'(i_bus.waitrequest), 32'd0);
        check("t5_after_rdata", i_bus.readdata, 32'h1234_5678);
        tick();
        i_bus.read = 1'b0;
        settle();
        check("t5_end_grant", 32'(grant), 32'(GNT_NONE));

        // ---- 6: 8-cycle stall against an 8-cycle watchdog ----
        wait_target   = 8;
        i_bus.address = 32'h0000_3000;
        i_bus.read    = 1'b1;
        settle();
        tick(); settle();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("t6_iwait_c%0d", c), 32'(i_bus.waitrequest), 32'd1);
            check($sformatf("t6_to_c%0d", c), 32'(timeout_err), 32'd0);
            tick(); settle();
        end
        check("t6_grant_done", 32'(grant), 32'(GNT_I));
        check("t6_iwait_done", 32'(i_bus.waitrequest), 32'd0);
        check("t6_rdata", i_bus.readdata, 32'h3333_3333);
        check("t6_to_done", 32'(timeout_err), 32'(TO_EXP));
        tick();
        i_bus.read = 1'b0;
        settle();
        check("t6_idle_grant", 32'(grant), 32'(GNT_NONE));
        check("t6_to_idle", 32'(timeout_err), 32'(TO_EXP));
        tick(); settle();
        check("t6_to_sticky", 32'(timeout_err), 32'(TO_EXP));
        reset = 1'b1;
        settle();
        check("t6_to_rst", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b0;
        settle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
